// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state type and geometry helpers for the banked RAM
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } ram_state_e;

   // Number of banks addressed by the bank-select field
   function automatic int calc_nbanks(input int bank_bits);
      return 1 << bank_bits;
   endfunction

   // Row field width left over once the bank field is taken from the address
   function automatic int calc_row_w(input int addr_w, input int bank_bits);
      return addr_w - bank_bits;
   endfunction

   // Words per bank
   function automatic int calc_bank_depth(input int row_w);
      return 1 << row_w;
   endfunction

endpackage

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - single bank: one write port, one registered read port
module ram_bank #(
   parameter int WIDTH = 16,
   parameter int ROW_W = 12
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [ROW_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [ROW_W-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int DEPTH = 1 << ROW_W;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write port; array has no reset, the top-level sweep clears it
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read; same-edge write is not yet visible (read-before-write)
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_banked_param.sv
// rtl/ram_banked_param.sv - banked sync-read RAM with clear sweep; optional RAM_BYPASS_EN write-first forwarding
module ram_banked_param
   import ram_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ADDR_W    = 14,
   parameter int BANK_BITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic [ADDR_W-1:0] address,
   input  logic              load,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              ready
);

   localparam int ROW_W      = calc_row_w(ADDR_W, BANK_BITS);
   localparam int NBANKS     = calc_nbanks(BANK_BITS);
   localparam int BANK_DEPTH = calc_bank_depth(ROW_W);

   ram_state_e           state_q, state_d;
   logic [ROW_W-1:0]     clr_cnt_q;
   logic                 clearing;
   logic [BANK_BITS-1:0] addr_bank;
   logic [ROW_W-1:0]     addr_row;
   logic                 rd_go, wr_go, clr_go;
   logic                 rd_pend_q;
   logic                 out_clr_q;
   logic [BANK_BITS-1:0] bank_sel_q;
   logic [WIDTH-1:0]     bank_rdata [NBANKS];
   logic [WIDTH-1:0]     bank_out;

   assign addr_bank = address[ADDR_W-1 -: BANK_BITS];
   assign addr_row  = address[ROW_W-1:0];

   // An asserted reset blocks every array access on that edge
   assign clr_go = clearing & ~reset;
   assign wr_go  = ready & load & ~reset;
   assign rd_go  = ready & rd_en & ~reset;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave CLEAR once the last row has been written
   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && clr_cnt_q == ROW_W'(BANK_DEPTH - 1)) begin
         state_d = RUN;
      end
   end

   // State-decoded outputs
   always_comb begin
      ready    = (state_q == RUN);
      clearing = (state_q == CLEAR);
   end

   // Sweep row counter, one row per cycle across all banks
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_cnt_q <= '0;
      end else if (clearing) begin
         clr_cnt_q <= clr_cnt_q + ROW_W'(1);
      end
   end

   // Banks; the sweep overrides the load demux while clearing
   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic sel;
      assign sel = (addr_bank == BANK_BITS'(b));

      ram_bank #(
         .WIDTH (WIDTH),
         .ROW_W (ROW_W)
      ) u_bank (
         .clk     (clk),
         .we_i    (clr_go | (wr_go & sel)),
         .waddr_i (clr_go ? clr_cnt_q : addr_row),
         .wdata_i (clr_go ? '0 : in),
         .re_i    (rd_go & sel),
         .raddr_i (addr_row),
         .rdata_o (bank_rdata[b])
      );
   end

   // Valid pulse and bank select travel one cycle alongside the read
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_q  <= 1'b0;
         out_clr_q  <= 1'b1;
         bank_sel_q <= '0;
      end else begin
         rd_pend_q <= rd_go;
         if (rd_go) begin
            bank_sel_q <= addr_bank;
            out_clr_q  <= 1'b0;
         end
      end
   end

   assign bank_out  = bank_rdata[bank_sel_q];
   assign out_valid = rd_pend_q;

`ifdef RAM_BYPASS_EN
   logic             byp_q;
   logic [WIDTH-1:0] byp_data_q;

   // Load and read share one address, so a same-cycle pair always collides
   always_ff @(posedge clk) begin
      if (reset) begin
         byp_q      <= 1'b0;
         byp_data_q <= '0;
      end else if (rd_go) begin
         byp_q      <= wr_go;
         byp_data_q <= in;
      end
   end

   // Output mux: zero after reset, else forwarded data or bank data; holds between reads
   always_comb begin
      out = bank_out;
      if (out_clr_q) begin
         out = '0;
      end else if (byp_q) begin
         out = byp_data_q;
      end
   end
`else
   // Output mux: zero after reset until the first read, else holds the last read bank data
   always_comb begin
      out = bank_out;
      if (out_clr_q) begin
         out = '0;
      end
   end
`endif

endmodule

// File: tb/tb_ram_banked_param.sv
// tb/tb_ram_banked_param.sv - self-checking bench for ram_banked_param
module tb_ram_banked_param;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] in = '0;
   logic [13:0] address = '0;
   logic        load = 1'b0;
   logic        rd_en = 1'b0;
   logic [15:0] out;
   logic        out_valid;
   logic        ready;

   always #5 clk = ~clk;

   ram_banked_param #(
      .WIDTH     (16),
      .ADDR_W    (14),
      .BANK_BITS (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .address   (address),
      .load      (load),
      .rd_en     (rd_en),
      .out       (out),
      .out_valid (out_valid),
      .ready     (ready)
   );

`ifdef RAM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic [15:0] model [0:16383];
   logic [15:0] last_out;
   int          n_pass = 0;
   int          n_checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      load  = 1'b0;
      rd_en = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 16384; i++) model[i] = 16'h0000;
      last_out = 16'h0000;
      check({tag, "_ready"}, ready, 0);
      check({tag, "_out"}, out, 0);
      check({tag, "_valid"}, out_valid, 0);
   endtask

   task automatic wait_ready(input string tag, input int already);
      int n;
      n = already;
      while (!ready && n < 5000) begin
         tick();
         n++;
      end
      check(tag, n, 4096);
   endtask

   task automatic wr(input logic [13:0] a, input logic [15:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      tick();
      load = 1'b0;
      model[a] = d;
   endtask

   task automatic rd_chk(input string tag, input logic [13:0] a);
      address = a;
      rd_en   = 1'b1;
      tick();
      rd_en = 1'b0;
      check({tag, "_valid"}, out_valid, 1);
      check(tag, out, model[a]);
      last_out = model[a];
      tick();
      check({tag, "_pulse"}, out_valid, 0);
      check({tag, "_hold"}, out, last_out);
   endtask

   initial begin
      logic [13:0] a;
      logic [15:0] d, exp;
      logic        ld, r;

      // Clear sweep from power-up
      do_reset("rst0");
      wait_ready("sweep_len", 0);
      rd_chk("clr_0000", 14'h0000);
      rd_chk("clr_2abc", 14'h2ABC);
      rd_chk("clr_3fff", 14'h3FFF);

      // Basic write/read
      wr(14'h0000, 16'hBEEF);
      wr(14'h3FFF, 16'h1234);
      rd_chk("rd_0000", 14'h0000);
      rd_chk("rd_3fff", 14'h3FFF);

      // Back-to-back reads
      address = 14'h3FFF;
      rd_en   = 1'b1;
      tick();
      address = 14'h0000;
      check("b2b_v0", out_valid, 1);
      check("b2b_d0", out, 16'h1234);
      tick();
      rd_en = 1'b0;
      check("b2b_v1", out_valid, 1);
      check("b2b_d1", out, 16'hBEEF);
      tick();
      check("b2b_end", out_valid, 0);
      last_out = 16'hBEEF;

      // Same row, different banks
      wr(14'h0005, 16'hAAAA);
      wr(14'h1005, 16'h5555);
      rd_chk("alias_b0", 14'h0005);
      rd_chk("alias_b1", 14'h1005);

      // Same-address load + read
      wr(14'h0100, 16'h1111);
      address = 14'h0100;
      in      = 16'h2222;
      load    = 1'b1;
      rd_en   = 1'b1;
      tick();
      load  = 1'b0;
      rd_en = 1'b0;
      check("coll_v", out_valid, 1);
      check("coll_d", out, BYP ? 16'h2222 : 16'h1111);
      model[14'h0100] = 16'h2222;
      rd_chk("coll_after", 14'h0100);

      // Reset at clr_cnt=100 and again in RUN
      wr(14'h0042, 16'h7777);
      do_reset("rst1");
      repeat (100) tick();
      do_reset("rst2");
      wait_ready("sweep_restart", 0);
      do_reset("rst3");
      wait_ready("sweep_run", 0);
      rd_chk("rd_0042", 14'h0042);

      // Accesses ignored during the sweep
      wr(14'h0003, 16'h3333);
      do_reset("rst4");
      address = 14'h0003;
      in      = 16'hFFFF;
      load    = 1'b1;
      rd_en   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("clr_ign_v", out_valid, 0);
      end
      load  = 1'b0;
      rd_en = 1'b0;
      wait_ready("sweep_ign", 20);
      rd_chk("rd_0003", 14'h0003);

      // Random traffic against the array model
      for (int i = 0; i < 400; i++) begin
         a  = 14'(($urandom_range(0, 3) << 12) | $urandom_range(0, 7));
         d  = 16'($urandom);
         ld = 1'($urandom);
         r  = 1'($urandom);
         exp = (ld && BYP) ? d : model[a];
         address = a;
         in      = d;
         load    = ld;
         rd_en   = r;
         tick();
         check("rnd_v", out_valid, r);
         if (r) last_out = exp;
         check("rnd_d", out, last_out);
         if (ld) model[a] = d;
      end
      load  = 1'b0;
      rd_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
